// File: rtl/mem_test_sequencer_pkg.sv
// Shared types for the memory test sequencer: sequencer states, test modes
// and the packed parameter payload handed to the memory manager.
package mem_test_sequencer_pkg;

    localparam int unsigned PULSE_WIDTH_W = 8;
    localparam int unsigned PULSE_GAP_W   = 8;
    localparam int unsigned CNT_W         = 16;

    typedef enum logic [1:0] {
        MODE_CONTINUOUS = 2'd0,
        MODE_PULSED     = 2'd1,
        MODE_MARCH      = 2'd2,
        MODE_RANDOM     = 2'd3
    } test_mode_e;

    typedef struct packed {
        test_mode_e               test_mode;
        logic [PULSE_GAP_W-1:0]   pulse_gap;
        logic [PULSE_WIDTH_W-1:0] pulse_width;
    } mem_params_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/mem_test_sequencer_if.sv
// Control/report bus between the test sequencer (master) and the memory manager (slave).
interface mem_test_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16
);
    import mem_test_sequencer_pkg::*;

    logic                            mm_run;
    mem_params_t                     mm_params;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] mm_replace_num;
    logic                            mm_replace_valid;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] mm_received_num;
    logic                            mm_received_replaced;
    logic                            mm_received_valid;
    logic                            mm_received_overrun;
    logic                            mm_received_ack;

    modport master (
        output mm_run, mm_params, mm_replace_num, mm_replace_valid, mm_received_ack,
        input  mm_received_num, mm_received_replaced, mm_received_valid, mm_received_overrun
    );

    modport slave (
        input  mm_run, mm_params, mm_replace_num, mm_replace_valid, mm_received_ack,
        output mm_received_num, mm_received_replaced, mm_received_valid, mm_received_overrun
    );

endinterface

// File: rtl/mem_report_buffer.sv
// One-entry report holding register with a valid/ready output stream;
// accepts a new entry in the same cycle the held one is taken.
module mem_report_buffer #(
    parameter int unsigned WIDTH = 25
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready_c,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    assign in_ready_c = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready_c) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_test_sequencer.sv
// Memory test sequencer: loads replacement words, runs the memory manager for a
// configured time, forwards received reports and counts mismatches/replacements.
module mem_test_sequencer
    import mem_test_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DUR_WIDTH  = 32
) (
    input  logic                           clk,
    input  logic                           n_reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [ADDR_WIDTH-1:0]          cfg_no_nums,
    input  logic [DATA_WIDTH-1:0]          cfg_pattern,
    input  logic [DUR_WIDTH-1:0]           cfg_duration,
    input  logic [PULSE_WIDTH_W-1:0]       cfg_pulse_width,
    input  logic [PULSE_GAP_W-1:0]         cfg_pulse_gap,
    input  test_mode_e                     cfg_test_mode,
    mem_test_sequencer_if.master           mm,
    output logic [ADDR_WIDTH+DATA_WIDTH:0] rpt_data,
    output logic                           rpt_valid,
    input  logic                           rpt_ready,
    output logic [CNT_W-1:0]               err_count,
    output logic [CNT_W-1:0]               rep_count,
    output logic                           overrun_flag,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned RPT_W = ADDR_WIDTH + DATA_WIDTH + 1;

    seq_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [DUR_WIDTH-1:0]  rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] no_nums_q;
    logic [DATA_WIDTH-1:0] pattern_q;
    logic [DUR_WIDTH-1:0]  duration_q;
    mem_params_t           params_q;
    logic                  accept_c, flush_c, capture_c, in_ready_c;
    logic [DATA_WIDTH-1:0] load_pattern_c;

    // Next-state logic; abort overrides every non-idle transition
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
        accept_c = 1'b0;
        flush_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                    idx_d    = '0;
                    state_d  = (cfg_no_nums == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                idx_d = idx_q + ADDR_WIDTH'(1);
                if (idx_q == no_nums_q - ADDR_WIDTH'(1)) begin
                    rem_d   = duration_q;
                    state_d = (duration_q == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                rem_d = rem_q - DUR_WIDTH'(1);
                if (rem_q == DUR_WIDTH'(1)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!rpt_valid) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            flush_c = 1'b1;
        end
    end

    // A report is taken only in RUN, and never in the cycle an abort lands
    assign capture_c = n_reset && (state_q == ST_RUN) && !abort
                       && mm.mm_received_valid && in_ready_c;
    assign mm.mm_received_ack = capture_c;
    assign mm.mm_params       = params_q;
    assign load_pattern_c     = accept_c ? cfg_pattern : pattern_q;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q             <= ST_IDLE;
            idx_q               <= '0;
            rem_q               <= '0;
            no_nums_q           <= '0;
            pattern_q           <= '0;
            duration_q          <= '0;
            params_q            <= '{test_mode: MODE_CONTINUOUS, pulse_gap: '0, pulse_width: '0};
            mm.mm_run           <= 1'b0;
            mm.mm_replace_valid <= 1'b0;
            mm.mm_replace_num   <= '0;
            err_count           <= '0;
            rep_count           <= '0;
            overrun_flag        <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
        end else begin
            state_q             <= state_d;
            idx_q               <= idx_d;
            rem_q               <= rem_d;
            mm.mm_run           <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
            mm.mm_replace_valid <= (state_d == ST_LOAD);
            busy                <= (state_d != ST_IDLE);
            done                <= (state_d == ST_DONE);
            if (state_d == ST_LOAD)
                mm.mm_replace_num <= {idx_d, DATA_WIDTH'(idx_d) ^ load_pattern_c};
            if (accept_c) begin
                no_nums_q    <= cfg_no_nums;
                pattern_q    <= cfg_pattern;
                duration_q   <= cfg_duration;
                params_q     <= '{test_mode: cfg_test_mode, pulse_gap: cfg_pulse_gap,
                                  pulse_width: cfg_pulse_width};
                err_count    <= '0;
                rep_count    <= '0;
                overrun_flag <= 1'b0;
            end else begin
                if (capture_c) begin
                    if (mm.mm_received_replaced) begin
                        if (rep_count != '1) rep_count <= rep_count + CNT_W'(1);
                    end else begin
                        if (err_count != '1) err_count <= err_count + CNT_W'(1);
                    end
                end
                if (mm.mm_received_overrun && (state_q == ST_RUN || state_q == ST_DRAIN))
                    overrun_flag <= 1'b1;
            end
        end
    end

    mem_report_buffer #(.WIDTH(RPT_W)) u_report_buffer (
        .clk        (clk),
        .n_reset    (n_reset),
        .flush      (flush_c),
        .in_valid   (capture_c),
        .in_ready_c (in_ready_c),
        .in_data    ({mm.mm_received_replaced, mm.mm_received_num}),
        .out_valid  (rpt_valid),
        .out_data   (rpt_data),
        .out_ready  (rpt_ready)
    );

endmodule
